// File: rtl/pb_debounce.sv
// rtl/pb_debounce.sv - push-button synchroniser, debouncer and press/release/long-press event generator
//
// Conditions the raw active-low S2 button for the LED controller: two-flop
// synchroniser into CLK, four-state debounce FSM, registered clean level and
// one-cycle event pulses.
//
// Ports:
//   CLK        in   system clock
//   RESETn     in   asynchronous active-low reset
//   PB_RAW     in   raw button pin, asynchronous to CLK, 0 = pressed
//   PB_CLEAN   out  debounced level, 0 = pressed, 1 = released (registered)
//   PRESS_P    out  one-cycle pulse when a press is accepted
//   RELEASE_P  out  one-cycle pulse when a release is accepted
//   LONG_P     out  one-cycle pulse once a press has been held LONG_CYCLES
//   HELD       out  high from LONG_P until the release is accepted

module pb_debounce #(
  parameter int DEB_CYCLES  = 250000,
  parameter int LONG_CYCLES = 50000000,
  parameter int CNT_W       = 26
) (
  input  logic CLK,
  input  logic RESETn,
  input  logic PB_RAW,
  output logic PB_CLEAN,
  output logic PRESS_P,
  output logic RELEASE_P,
  output logic LONG_P,
  output logic HELD
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_UP      = 2'd0,
    ST_TO_DOWN = 2'd1,
    ST_DOWN    = 2'd2,
    ST_TO_UP   = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic             sync1, sync2;
  logic [CNT_W-1:0] deb_cnt, deb_nxt;
  logic [CNT_W-1:0] long_cnt, long_nxt;
  logic             clean_nxt, press_nxt, release_nxt, long_p_nxt, held_nxt;

  // Synchroniser resets to the released level so reset never looks like a press.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= PB_RAW;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state     <= ST_UP;
      deb_cnt   <= '0;
      long_cnt  <= '0;
      PB_CLEAN  <= 1'b1;
      PRESS_P   <= 1'b0;
      RELEASE_P <= 1'b0;
      LONG_P    <= 1'b0;
      HELD      <= 1'b0;
    end else begin
      state     <= state_nxt;
      deb_cnt   <= deb_nxt;
      long_cnt  <= long_nxt;
      PB_CLEAN  <= clean_nxt;
      PRESS_P   <= press_nxt;
      RELEASE_P <= release_nxt;
      LONG_P    <= long_p_nxt;
      HELD      <= held_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    deb_nxt     = deb_cnt;
    long_nxt    = long_cnt;
    clean_nxt   = PB_CLEAN;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    long_p_nxt  = 1'b0;
    held_nxt    = HELD;

    case (state)
      ST_UP: begin
        if (!sync2) state_nxt = ST_TO_DOWN;
      end

      ST_TO_DOWN: begin
        if (sync2) begin
          state_nxt = ST_UP;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt = ST_DOWN;
          clean_nxt = 1'b0;
          press_nxt = 1'b1;
          long_nxt  = '0;
        end else begin
          deb_nxt = deb_cnt + CNT_ONE;
        end
      end

      ST_DOWN: begin
        // The long-press check is independent of the release check, so a
        // threshold hit in the same cycle sync2 rises still fires LONG_P.
        if (long_cnt != LONG_LAST) begin
          long_nxt = long_cnt + CNT_ONE;
        end else if (!HELD) begin
          long_p_nxt = 1'b1;
          held_nxt   = 1'b1;
        end
        if (sync2) state_nxt = ST_TO_UP;
      end

      ST_TO_UP: begin
        // long_cnt is left alone here so a release bounce does not restart
        // the long-press timer.
        if (!sync2) begin
          state_nxt = ST_DOWN;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt   = ST_UP;
          clean_nxt   = 1'b1;
          release_nxt = 1'b1;
          held_nxt    = 1'b0;
        end else begin
          deb_nxt = deb_cnt + CNT_ONE;
        end
      end

      default: state_nxt = ST_UP;
    endcase

    // Every state change restarts the debounce window.
    if (state_nxt != state) deb_nxt = '0;
  end

endmodule

// File: tb/tb_pb_debounce.sv
// tb/tb_pb_debounce.sv - scoreboard bench for pb_debounce with directed press/release/bounce/long/reset vectors

module tb_pb_debounce;

  logic CLK;
  logic RESETn;
  logic PB_RAW;
  logic PB_CLEAN, PRESS_P, RELEASE_P, LONG_P, HELD;

  pb_debounce #(
    .DEB_CYCLES (4),
    .LONG_CYCLES(16),
    .CNT_W      (8)
  ) dut (
    .CLK      (CLK),
    .RESETn   (RESETn),
    .PB_RAW   (PB_RAW),
    .PB_CLEAN (PB_CLEAN),
    .PRESS_P  (PRESS_P),
    .RELEASE_P(RELEASE_P),
    .LONG_P   (LONG_P),
    .HELD     (HELD)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Number of rising edges so far; stable when read on the falling edge.
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  localparam int EV_PRESS   = 0;
  localparam int EV_RELEASE = 1;
  localparam int EV_LONG    = 2;

  typedef struct {
    int   kind;
    int   edge_n;
    logic clean;
    logic held;
  } ev_t;

  ev_t sb[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  function automatic string kind_name(int k);
    case (k)
      EV_PRESS:   return "press";
      EV_RELEASE: return "release";
      default:    return "long";
    endcase
  endfunction

  task automatic expect_ev(input int kind, input int e, input logic c, input logic h);
    ev_t ev;
    ev.kind   = kind;
    ev.edge_n = e;
    ev.clean  = c;
    ev.held   = h;
    sb.push_back(ev);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Called just after a falling edge; k is the rising edge that first samples v.
  task automatic drive(input logic v, output int k);
    PB_RAW = v;
    k = cyc + 1;
  endtask

  task automatic check_out(input string name, input logic [4:0] exp);
    logic [4:0] act;
    act = {PB_CLEAN, PRESS_P, RELEASE_P, LONG_P, HELD};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: {clean,press,release,long,held} got %b, required %b at edge %0d",
               name, act, exp, cyc);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b at edge %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT emits a pulse.
  always @(negedge CLK) begin : monitor
    ev_t  e;
    logic p;
    if (RESETn) begin
      while (sb.size() > 0 && sb[0].edge_n < cyc) begin
        e = sb.pop_front();
        n_checks++;
        n_fail++;
        $display("FAIL missed_%s: no pulse seen, required at edge %0d (now %0d)",
                 kind_name(e.kind), e.edge_n, cyc);
      end
      for (int t = 0; t < 3; t++) begin
        p = (t == EV_PRESS) ? PRESS_P : (t == EV_RELEASE) ? RELEASE_P : LONG_P;
        if (p) begin
          n_checks++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_%s: pulse at edge %0d, required none", kind_name(t), cyc);
          end else begin
            e = sb.pop_front();
            if (e.kind != t || e.edge_n != cyc || e.clean !== PB_CLEAN || e.held !== HELD) begin
              n_fail++;
              $display("FAIL event_%s: got %s@%0d clean=%b held=%b, required %s@%0d clean=%b held=%b",
                       kind_name(e.kind), kind_name(t), cyc, PB_CLEAN, HELD,
                       kind_name(e.kind), e.edge_n, e.clean, e.held);
            end
          end
        end
      end
    end
  end

  initial begin : stim
    int k, r, p, dummy;
    RESETn = 1'b0;
    PB_RAW = 1'b1;

    // Reset held while the pin toggles: outputs must stay at reset values.
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      PB_RAW = ~PB_RAW;
      @(negedge CLK);
      check_out("reset_hold", 5'b10000);
    end
    PB_RAW = 1'b1;
    tick(3);
    RESETn = 1'b1;
    tick(3);

    // Clean press, held past the long threshold, then released.
    drive(1'b0, k);
    expect_ev(EV_PRESS, k + 6, 1'b0, 1'b0);
    expect_ev(EV_LONG, k + 22, 1'b0, 1'b1);
    tick(6);
    check_bit("clean_before_press", PB_CLEAN, 1'b1);
    tick(24);
    drive(1'b1, r);
    expect_ev(EV_RELEASE, r + 6, 1'b1, 1'b0);
    tick(12);

    // Press bounce: low 3, high 2, then low steady; released before long.
    drive(1'b0, dummy);
    tick(3);
    drive(1'b1, dummy);
    tick(2);
    drive(1'b0, k);
    expect_ev(EV_PRESS, k + 6, 1'b0, 1'b0);
    tick(8);
    drive(1'b1, r);
    expect_ev(EV_RELEASE, r + 6, 1'b1, 1'b0);
    tick(12);

    // Release bounce: two TO_UP cycles delay LONG_P by two edges.
    drive(1'b0, k);
    p = k + 6;
    expect_ev(EV_PRESS, p, 1'b0, 1'b0);
    expect_ev(EV_LONG, p + 18, 1'b0, 1'b1);
    tick(11);
    drive(1'b1, dummy);
    tick(2);
    drive(1'b0, dummy);
    tick(4);
    check_bit("clean_after_release_bounce", PB_CLEAN, 1'b0);
    tick(15);
    drive(1'b1, r);
    expect_ev(EV_RELEASE, r + 6, 1'b1, 1'b0);
    tick(12);

    // Long press held 30 cycles past PRESS_P.
    drive(1'b0, k);
    p = k + 6;
    expect_ev(EV_PRESS, p, 1'b0, 1'b0);
    expect_ev(EV_LONG, p + 16, 1'b0, 1'b1);
    tick(16);
    check_bit("held_before_long", HELD, 1'b0);
    tick(10);
    check_bit("held_after_long", HELD, 1'b1);
    check_bit("clean_while_held", PB_CLEAN, 1'b0);
    tick(10);
    drive(1'b1, r);
    expect_ev(EV_RELEASE, r + 6, 1'b1, 1'b0);
    tick(12);
    check_bit("held_after_release", HELD, 1'b0);

    // Reset two cycles into TO_DOWN with the button held.
    drive(1'b0, k);
    tick(5);
    RESETn = 1'b0;
    #1;
    check_out("reset_async", 5'b10000);
    tick(2);
    check_out("reset_mid", 5'b10000);
    RESETn = 1'b1;
    k = cyc + 1;
    expect_ev(EV_PRESS, k + 6, 1'b0, 1'b0);
    tick(10);
    drive(1'b1, r);
    expect_ev(EV_RELEASE, r + 6, 1'b1, 1'b0);
    tick(12);

    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d events outstanding, required 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pb_debounce.md
# pb_debounce

Push-button conditioning stage for the SmartFusion2 Starter Kit LED demo. It sits directly upstream of the LED control block. It synchronises the raw, bouncing, active-low S2 input into the CLK domain and debounces it with a four-state FSM. Its outputs are a clean active-low level, which drives the LED controller's PB_SW input, plus one-cycle press, release and long-press event pulses.

## Interface
Parameters:
- DEB_CYCLES, 250000 — consecutive stable cycles required to accept a level change (5 ms at 50 MHz); legal range 2 to 2^CNT_W−1.
- LONG_CYCLES, 50000000 — cycles in the accepted-pressed state before a long-press is flagged (1 s at 50 MHz); legal range 2 to 2^CNT_W−1.
- CNT_W, 26 — width of both internal counters.

Ports:
- CLK  in  1  system clock.
- RESETn  in  1  asynchronous, active-low reset.
- PB_RAW  in  1  raw push-button pin, asynchronous to CLK; 0 = pressed.
- PB_CLEAN  out  1  debounced level; 0 = pressed, 1 = released; registered.
- PRESS_P  out  1  one-cycle pulse when a press is accepted.
- RELEASE_P  out  1  one-cycle pulse when a release is accepted.
- LONG_P  out  1  one-cycle pulse when a press has been held LONG_CYCLES.
- HELD  out  1  high from LONG_P until the release is accepted.

## Operation
- **Synchroniser.** Two flops, sync1 then sync2, both reset to 1. The FSM sees only sync2.
- **Debounce counter (deb_cnt).** Cleared on every FSM state change.
- **Long counter (long_cnt).**
  - Cleared on the TO_DOWN→DOWN transition.
  - Increments each cycle in DOWN, saturating at LONG_CYCLES−1.
  - Holds its value in TO_UP.
- **FSM states:** UP, TO_DOWN, DOWN, TO_UP. Reset state is UP.
- **UP:**
  - sync2=0 → TO_DOWN, deb_cnt←0.
  - Otherwise stay.
- **TO_DOWN:**
  - sync2=1 → UP (bounce rejected, no pulse).
  - sync2=0 and deb_cnt=DEB_CYCLES−1 → DOWN. PB_CLEAN←0, PRESS_P←1.
  - Otherwise deb_cnt+1.
- **DOWN:**
  - sync2=1 → TO_UP, deb_cnt←0.
  - When long_cnt=DEB… no: when long_cnt=LONG_CYCLES−1 and HELD=0, set LONG_P←1 and HELD←1. This fires exactly once per accepted press.
- **TO_UP:**
  - sync2=0 → DOWN. long_cnt resumes from its held value; no new PRESS_P.
  - sync2=1 and deb_cnt=DEB_CYCLES−1 → UP. PB_CLEAN←1, RELEASE_P←1, HELD←0.
  - Otherwise deb_cnt+1.
- **Pulses.** PRESS_P, RELEASE_P and LONG_P default to 0 every cycle.
- **Simultaneous events.** If the long threshold is reached in the same cycle that sync2 rises in DOWN, both actions occur: LONG_P/HELD are set and the FSM moves to TO_UP.
- **Output relationships.** PB_CLEAN changes only together with PRESS_P or RELEASE_P. HELD=1 implies PB_CLEAN=0.
- **Counter widths.** Both counters are CNT_W bits wide. Comparisons are equality against (parameter−1) truncated to CNT_W. Neither counter wraps.

## Timing
- **Reset values** (asynchronous, immediate):
  - PB_CLEAN=1; PRESS_P=RELEASE_P=LONG_P=HELD=0.
  - State UP; sync1=sync2=1; deb_cnt=long_cnt=0.
- **Press latency.** PB_RAW falls and is first sampled low at edge k, with no bounce after that. Then:
  - sync2=0 after edge k+1.
  - TO_DOWN after edge k+2.
  - PB_CLEAN=0 and PRESS_P high after edge k+2+DEB_CYCLES, for one cycle.
- **Release latency.** Symmetric: RELEASE_P/PB_CLEAN after edge k+2+DEB_CYCLES from the first edge sampling 1.
- **Long press.** DOWN is entered at edge D and the button stays pressed. LONG_P and HELD assert after edge D+LONG_CYCLES−1+1, i.e. D+LONG_CYCLES.
- **Glitch rejection.** A raw glitch shorter than DEB_CYCLES+1 cycles, after synchronisation, produces no pulse and no PB_CLEAN change.
- **Reset mid-debounce or mid-long-press.** All state returns to reset values and no pulse is emitted. With the button still held at reset release, a full press debounce runs and yields PRESS_P.

## Test plan
Directed tests use DEB_CYCLES=4, LONG_CYCLES=16, CNT_W=8.

- **Reset.** Hold RESETn=0 while PB_RAW toggles → PB_CLEAN=1 and all pulses/HELD 0 throughout.
- **Clean press.** PB_RAW 1→0 first sampled at edge 10, then held → PRESS_P high only after edge 16 and PB_CLEAN=0 from edge 16. Release at edge 40 → RELEASE_P and PB_CLEAN=1 after edge 46.
- **Bounce on press.** PB_RAW low 3 cycles, high 2, then low steady → no pulse during the bounce. Exactly one PRESS_P, 6 edges after the final low is first sampled.
- **Bounce on release.** In DOWN, PB_RAW high 2 cycles then low again → no RELEASE_P and PB_CLEAN stays 0. long_cnt is not reset, so LONG_P still arrives 16 DOWN-cycles after entry, excluding the TO_UP cycles.
- **Long press.** Hold 30 cycles past PRESS_P → exactly one LONG_P, 16 edges after the DOWN entry, and HELD=1. Release → HELD=0 in the same cycle as RELEASE_P.
- **Reset mid-operation.** Assert RESETn low 2 cycles into TO_DOWN with the button held → immediate reset values. After RESETn rises, PRESS_P occurs 6 edges after sync.
